vend_sequencer: RTL

- Central controller for the vending datapath.
- Owns the single credit register.
- Arbitrates between three requesters: coin acceptance (add), item selection and dispense (subtract), and change return (decrement per returned coin).
- Sits between the coin accepter/keypad decoder upstream and the dispense/change units downstream; drives the credit value shown on the 3-digit display.

---
 rtl/vend_pkg.sv | 47 ++++
 rtl/vend_timer.sv | 33 +++
 rtl/vend_sequencer.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/vend_pkg.sv
// Shared types and constants for the vending sequencer: state encoding, item codes,
// coin values and the 9-bit internal credit width.
package vend_pkg;

   localparam int CREDIT_W = 9;
   localparam int TIMER_W  = 24;

   typedef logic [CREDIT_W-1:0] credit_t;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_CREDIT   = 2'd1,
      ST_DISPENSE = 2'd2,
      ST_CHANGE   = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      ITEM_GUM     = 2'd0,
      ITEM_CANDY   = 2'd1,
      ITEM_COOKIES = 2'd2,
      ITEM_CHIPS   = 2'd3
   } item_t;

   localparam credit_t VAL_DOLLAR  = 9'd100;
   localparam credit_t VAL_QUARTER = 9'd25;
   localparam credit_t VAL_DIME    = 9'd10;
   localparam credit_t VAL_NICKEL  = 9'd5;

   // Value of a coin given the one-hot {dollar,quarter,dime,nickel} code; 0 if not one-hot.
   function automatic credit_t coin_value(input logic [3:0] sel);
      case (sel)
         4'b1000: return VAL_DOLLAR;
         4'b0100: return VAL_QUARTER;
         4'b0010: return VAL_DIME;
         4'b0001: return VAL_NICKEL;
         default: return credit_t'(0);
      endcase
   endfunction

   // Total value ejected by the change unit in one cycle (pulses may coincide).
   function automatic credit_t ret_total(input logic q, input logic d, input logic n);
      return (q ? VAL_QUARTER : credit_t'(0)) +
             (d ? VAL_DIME    : credit_t'(0)) +
             (n ? VAL_NICKEL  : credit_t'(0));
   endfunction

endpackage

// File: rtl/vend_timer.sv
// Inactivity counter for the credit-hold state; only built when VEND_TIMEOUT_EN is defined.
// Held at 0 while disabled, reloaded to 0 on load, o_expire once TIMEOUT_CYC quiet cycles elapse.
`ifdef VEND_TIMEOUT_EN
module vend_timer
   import vend_pkg::*;
#(
   parameter logic [TIMER_W-1:0] TIMEOUT_CYC = 24'd10_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic i_en,
   input  logic i_load,
   output logic o_expire
);

   localparam logic [TIMER_W-1:0] LAST = TIMEOUT_CYC - 1'b1;

   logic [TIMER_W-1:0] r_count;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_count <= '0;
      end else if (!i_en || i_load) begin
         r_count <= '0;
      end else if (r_count != LAST) begin
         r_count <= r_count + 1'b1;
      end
   end

   assign o_expire = i_en && (r_count == LAST);

endmodule
`endif

// File: rtl/vend_sequencer.sv
// Vending controller: owns the credit register and arbitrates coin, selection and change.
// Optional inactivity refund is enabled by defining VEND_TIMEOUT_EN.
module vend_sequencer
   import vend_pkg::*;
#(
   parameter int PRICE_GUM     = 50,
   parameter int PRICE_CANDY   = 75,
   parameter int PRICE_COOKIES = 100,
   parameter int PRICE_CHIPS   = 125,
   parameter int MAX_CREDIT    = 200,
   parameter logic [TIMER_W-1:0] TIMEOUT_CYC = 24'd10_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       coin_req,
   input  logic [3:0] coin_sel,
   input  logic       sel_req,
   input  logic [1:0] sel_item,
   input  logic       cancel,
   input  logic       disp_ack,
   input  logic       ret_q,
   input  logic       ret_d,
   input  logic       ret_n,
   input  logic       change_done,
   output logic [7:0] credit,
   output logic       coin_reject,
   output logic       sel_nack,
   output logic [3:0] dispense,
   output logic       change_start,
   output logic       busy
);

   localparam credit_t MAX_CREDIT_C = credit_t'(MAX_CREDIT);

   state_t     r_state;
   credit_t    r_credit;
   logic       r_coin_reject;
   logic       r_sel_nack;
   logic [3:0] r_dispense;
   logic       r_change_start;
   logic       r_busy;
   logic       r_err;

   credit_t w_coin_val;
   credit_t w_price;
   credit_t w_ret_sum;
   credit_t w_credit_after_ret;
   logic    w_coin_fits;
   logic    w_price_ok;
   logic    w_cancel_eff;
   logic    w_ret_over;
   logic    w_timeout;

   // The 9-bit sum cannot wrap (255 + 100 < 512), so the ceiling compare is exact.
   assign w_coin_val  = coin_value(coin_sel);
   assign w_coin_fits = $onehot(coin_sel) && ((r_credit + w_coin_val) <= MAX_CREDIT_C);

   // NOTE: give every always_comb output a default first, so no path infers a latch.
   always_comb begin
      w_price = credit_t'(PRICE_GUM);
      case (item_t'(sel_item))
         ITEM_CANDY:   w_price = credit_t'(PRICE_CANDY);
         ITEM_COOKIES: w_price = credit_t'(PRICE_COOKIES);
         ITEM_CHIPS:   w_price = credit_t'(PRICE_CHIPS);
         default:      w_price = credit_t'(PRICE_GUM);
      endcase
   end

   assign w_price_ok   = (r_credit >= w_price);
   assign w_cancel_eff = cancel && (r_state == ST_CREDIT);

   assign w_ret_sum          = ret_total(ret_q, ret_d, ret_n);
   assign w_ret_over         = (w_ret_sum > r_credit);
   assign w_credit_after_ret = w_ret_over ? credit_t'(0) : (r_credit - w_ret_sum);

`ifdef VEND_TIMEOUT_EN
   logic w_expire;

   vend_timer #(
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_timer (
      .clk      (clk),
      .rst      (rst),
      .i_en     (r_state == ST_CREDIT),
      .i_load   (coin_req || sel_req || cancel),
      .o_expire (w_expire)
   );

   assign w_timeout = (r_state == ST_CREDIT) && w_expire && !(coin_req || sel_req || cancel);
`else
   assign w_timeout = 1'b0;
`endif

   // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state        <= ST_IDLE;
         r_credit       <= '0;
         r_coin_reject  <= 1'b0;
         r_sel_nack     <= 1'b0;
         r_dispense     <= '0;
         r_change_start <= 1'b0;
         r_busy         <= 1'b0;
         r_err          <= 1'b0;
      end else begin
         r_coin_reject <= 1'b0;
         r_sel_nack    <= 1'b0;
         case (r_state)
            ST_IDLE, ST_CREDIT: begin
               // Priority cancel > coin > select; a losing request is refused, not queued.
               r_coin_reject <= coin_req && (w_cancel_eff || !w_coin_fits);
               r_sel_nack    <= sel_req && (coin_req || w_cancel_eff ||
                                            (r_state == ST_IDLE) || !w_price_ok);
               if (w_cancel_eff || w_timeout) begin
                  r_state        <= ST_CHANGE;
                  r_change_start <= 1'b1;
                  r_busy         <= 1'b1;
               end else if (coin_req) begin
                  if (w_coin_fits) begin
                     r_credit <= r_credit + w_coin_val;
                     r_state  <= ST_CREDIT;
                  end
               end else if (sel_req && (r_state == ST_CREDIT) && w_price_ok) begin
                  r_credit   <= r_credit - w_price;
                  r_dispense <= 4'b0001 << sel_item;
                  r_state    <= ST_DISPENSE;
                  r_busy     <= 1'b1;
               end
            end

            ST_DISPENSE: begin
               r_coin_reject <= coin_req;
               if (disp_ack) begin
                  r_dispense <= '0;
                  if (r_credit != '0) begin
                     r_state        <= ST_CHANGE;
                     r_change_start <= 1'b1;
                  end else begin
                     r_state <= ST_IDLE;
                     r_busy  <= 1'b0;
                  end
               end
            end

            ST_CHANGE: begin
               r_coin_reject <= coin_req;
               r_credit      <= w_credit_after_ret;
               r_err         <= r_err | w_ret_over;
               // change_done while credit remains keeps change_start high as a retry.
               if (change_done && (w_credit_after_ret == '0)) begin
                  r_state        <= ST_IDLE;
                  r_change_start <= 1'b0;
                  r_busy         <= 1'b0;
               end
            end

            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign credit       = r_credit[7:0];
   assign coin_reject  = r_coin_reject;
   assign sel_nack     = r_sel_nack;
   assign dispense     = r_dispense;
   assign change_start = r_change_start;
   assign busy         = r_busy;

endmodule
